cla_pipe_subtractor: RTL and testbench



---
 rtl/cla_pipe_subtractor_if.sv | 46 ++++
 rtl/cla_pipe_subtractor.sv | 186 ++++++++++++++++++
 tb/tb_cla_pipe_subtractor.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_subtractor_if.sv
// ---------------------------------------------------------------------------
// cla_pipe_subtractor_if
//
// Purpose:
//   Bundles the operand-side and result-side valid/ready handshakes of the
//   pipelined CLA subtractor into one interface.
//
// Signals:
//   in_valid   operands present on a, b, bin
//   in_ready   subtractor accepts operands this cycle
//   a, b       minuend / subtrahend (WIDTH bits)
//   bin        borrow in
//   out_valid  result present on diff, bout, ovf
//   out_ready  downstream accepts the result
//   diff       a - b - bin modulo 2^WIDTH (or saturated, see the core)
//   bout       borrow out
//   ovf        signed two's-complement overflow
//
// Modports:
//   master  the side that supplies operands and consumes results
//   slave   the subtractor itself
// ---------------------------------------------------------------------------
interface cla_pipe_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/cla_pipe_subtractor.sv
// ---------------------------------------------------------------------------
// cla_pipe_subtractor
//
// Purpose:
//   Pipelined WIDTH-bit subtractor, diff = a - b - bin, built as a + ~b + ~bin
//   from SLICE-bit carry-lookahead slices. Each pipeline stage resolves one
//   slice and registers its carry for the next stage. A final output register
//   derives borrow and signed overflow, giving a latency of exactly
//   STAGES cycles from the accepting edge to out_valid. Full throughput of
//   one operation per cycle; the whole pipe freezes while the result is
//   stalled at the output.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   cla_pipe_subtractor_if.slave (operand/result handshakes)
//
// Parameters:
//   WIDTH   operand/result width, a multiple of SLICE (minimum 4)
//   SLICE   bits per lookahead slice and per pipeline stage
//   STAGES  derived pipeline depth (WIDTH/SLICE), not overridable
//
// Configuration macro:
//   CLA_SUB_SAT_EN  when defined, an overflowing result is replaced by the
//                   signed saturation value of a's sign; bout and ovf are
//                   reported unchanged.
// ---------------------------------------------------------------------------
module cla_pipe_subtractor #(
    parameter  int WIDTH  = 16,
    parameter  int SLICE  = 4,
    localparam int STAGES = WIDTH / SLICE
) (
    input logic                  clk,
    input logic                  rst,
    cla_pipe_subtractor_if.slave bus
);

    // One lookahead slice: returns {carry_out, sum}. yInv is the already
    // inverted subtrahend slice, so the slice is a plain adder.
    function automatic logic [SLICE:0] claSlice(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] yInv,
        input logic             cin
    );
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   c;
        g    = x & yInv;
        p    = x ^ yInv;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

    logic             stValid_q [STAGES];
    logic [WIDTH-1:0] stA_q     [STAGES];
    logic [WIDTH-1:0] stB_q     [STAGES];
    logic [WIDTH-1:0] stDiff_q  [STAGES];
    logic             stCarry_q [STAGES];

    logic             stValid_d [STAGES];
    logic [WIDTH-1:0] stA_d     [STAGES];
    logic [WIDTH-1:0] stB_d     [STAGES];
    logic [WIDTH-1:0] stDiff_d  [STAGES];
    logic             stCarry_d [STAGES];

    logic             outValid_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    logic [WIDTH-1:0] diff_d;
    logic             bout_d;
    logic             ovf_d;

    logic             stall;

    // The result is parked at the output and nobody takes it: freeze the
    // whole pipe, bubbles included, and refuse new operands.
    assign stall = outValid_q && !bus.out_ready;

    // Stage k resolves slice k. Stage 0 works straight from the operand bus
    // (carry-in is the inverted borrow); later stages work from the register
    // of the stage before. Operands travel unchanged, lower slices of the
    // difference accumulate as the operation moves down.
    for (genvar k = 0; k < STAGES; k++) begin : gStage
        logic [WIDTH-1:0] srcA;
        logic [WIDTH-1:0] srcB;
        logic [WIDTH-1:0] srcDiff;
        logic             srcCarry;
        logic             srcValid;
        logic [SLICE:0]   sliceOut;
        logic [WIDTH-1:0] mergedDiff;

        if (k == 0) begin : gFirst
            assign srcA     = bus.a;
            assign srcB     = bus.b;
            assign srcDiff  = '0;
            assign srcCarry = ~bus.bin;
            assign srcValid = bus.in_valid;
        end else begin : gNext
            assign srcA     = stA_q[k-1];
            assign srcB     = stB_q[k-1];
            assign srcDiff  = stDiff_q[k-1];
            assign srcCarry = stCarry_q[k-1];
            assign srcValid = stValid_q[k-1];
        end

        assign sliceOut = claSlice(srcA[k*SLICE +: SLICE],
                                   ~srcB[k*SLICE +: SLICE],
                                   srcCarry);

        // Drop this slice's sum bits into the travelling difference.
        always_comb begin
            mergedDiff                   = srcDiff;
            mergedDiff[k*SLICE +: SLICE] = sliceOut[SLICE-1:0];
        end

        assign stValid_d[k] = srcValid;
        assign stA_d[k]     = srcA;
        assign stB_d[k]     = srcB;
        assign stDiff_d[k]  = mergedDiff;
        assign stCarry_d[k] = sliceOut[SLICE];
    end

    // Output stage: borrow is the inverted carry out of the top slice, and
    // overflow is only possible when the operand signs differ and the result
    // sign departs from the minuend's sign.
    always_comb begin
        bout_d = ~stCarry_q[STAGES-1];
        ovf_d  = (stA_q[STAGES-1][WIDTH-1] != stB_q[STAGES-1][WIDTH-1]) &&
                 (stDiff_q[STAGES-1][WIDTH-1] != stA_q[STAGES-1][WIDTH-1]);
        diff_d = stDiff_q[STAGES-1];
`ifdef CLA_SUB_SAT_EN
        if (ovf_d) begin
            diff_d = stA_q[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Pipeline and output registers. Everything advances together unless
    // stalled; data registers only load behind a valid so that idle results
    // keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stValid_q[k] <= 1'b0;
                stA_q[k]     <= '0;
                stB_q[k]     <= '0;
                stDiff_q[k]  <= '0;
                stCarry_q[k] <= 1'b0;
            end
            outValid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                stValid_q[k] <= stValid_d[k];
                if (stValid_d[k]) begin
                    stA_q[k]     <= stA_d[k];
                    stB_q[k]     <= stB_d[k];
                    stDiff_q[k]  <= stDiff_d[k];
                    stCarry_q[k] <= stCarry_d[k];
                end
            end
            outValid_q <= stValid_q[STAGES-1];
            if (stValid_q[STAGES-1]) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.out_valid = outValid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_subtractor.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_subtractor
//
// Purpose:
//   Directed-vector bench for cla_pipe_subtractor at WIDTH=16, SLICE=4.
//   Expected results are hand-computed constants held in the vector tables.
//   Covers asynchronous reset, exact latency, back-to-back throughput,
//   backpressure holding, and reset with operations in flight.
//   Honours CLA_SUB_SAT_EN for the expected value of overflowing results.
// ---------------------------------------------------------------------------
module tb_cla_pipe_subtractor;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks   = 0;
    int failures = 0;

    vec_t dirVecs [6];
    vec_t thrVecs [8];

    cla_pipe_subtractor_if #(.WIDTH(16)) bus ();

    cla_pipe_subtractor #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the design wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [15:0] a, input logic [15:0] b,
                                   input logic bin, input logic [15:0] d,
                                   input logic bo, input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.bin = bin; v.diff = d; v.bout = bo; v.ovf = ov;
        return v;
    endfunction

    // Raw wrapped difference, or the saturated value when that build option
    // is on and the vector overflows.
    function automatic logic [15:0] expDiff(input vec_t v);
`ifdef CLA_SUB_SAT_EN
        if (v.ovf) return v.a[15] ? 16'h8000 : 16'h7FFF;
`endif
        return v.diff;
    endfunction

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input vec_t v);
        checkOutput({tag, ".diff"}, 32'(bus.diff), 32'(expDiff(v)));
        checkOutput({tag, ".bout"}, 32'(bus.bout), 32'(v.bout));
        checkOutput({tag, ".ovf"},  32'(bus.ovf),  32'(v.ovf));
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.a        = v.a;
        bus.b        = v.b;
        bus.bin      = v.bin;
        bus.in_valid = 1'b1;
    endtask

    initial begin
        int outCount;
        int firstCyc;
        int lastCyc;
        int inIdx;
        int outIdx;
        int stray;
        logic prevStall;
        logic accept;

        dirVecs[0] = mkVec(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        dirVecs[1] = mkVec(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        dirVecs[2] = mkVec(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0);
        dirVecs[3] = mkVec(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        dirVecs[4] = mkVec(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
        dirVecs[5] = mkVec(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        thrVecs[0] = mkVec(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);
        thrVecs[1] = mkVec(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        thrVecs[2] = mkVec(16'h0001, 16'h0002, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        thrVecs[3] = mkVec(16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b1, 1'b1);
        thrVecs[4] = mkVec(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0);
        thrVecs[5] = mkVec(16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0);
        thrVecs[6] = mkVec(16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        thrVecs[7] = mkVec(16'h5555, 16'hAAAA, 1'b0, 16'hAAAB, 1'b1, 1'b1);

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        checkOutput("rst.outValid", 32'(bus.out_valid), 0);
        checkOutput("rst.diff",     32'(bus.diff),      0);
        checkOutput("rst.bout",     32'(bus.bout),      0);
        checkOutput("rst.ovf",      32'(bus.ovf),       0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rst.inReady", 32'(bus.in_ready), 1);

        // Isolated operations: out_valid must rise exactly 4 cycles after
        // the accepting edge and not earlier.
        $display("[TB] latency vectors");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(dirVecs[i]);
            checkOutput($sformatf("lat%0d.inReady", i), 32'(bus.in_ready), 1);
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            for (int c = 1; c <= 4; c++) begin
                @(posedge clk);
                #1;
                if (c < 4) begin
                    checkOutput($sformatf("lat%0d.early%0d", i, c), 32'(bus.out_valid), 0);
                end else begin
                    checkOutput($sformatf("lat%0d.valid", i), 32'(bus.out_valid), 1);
                    checkResult($sformatf("lat%0d", i), dirVecs[i]);
                end
            end
        end

        // Eight back-to-back operations: eight consecutive results in order.
        $display("[TB] throughput");
        outCount = 0;
        firstCyc = -1;
        lastCyc  = -1;
        for (int c = 0; c < 16; c++) begin
            if (c < 8) applyStimulus(thrVecs[c]);
            else       bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                if (outCount < 8) checkResult($sformatf("thr%0d", outCount), thrVecs[outCount]);
                else              checkOutput("thr.extra", 1, 0);
                if (firstCyc < 0) firstCyc = c;
                lastCyc = c;
                outCount++;
            end
        end
        checkOutput("thr.count", outCount, 8);
        checkOutput("thr.first", firstCyc, 4);
        checkOutput("thr.span",  lastCyc - firstCyc, 7);

        // Backpressure: out_ready low for three cycles mid-stream. The head
        // result must stay put, in_ready must drop, nothing lost or repeated.
        $display("[TB] backpressure");
        inIdx     = 0;
        outIdx    = 0;
        prevStall = 1'b0;
        for (int c = 0; c < 30; c++) begin
            bus.out_ready = !(c >= 6 && c < 9);
            if (inIdx < 8) applyStimulus(thrVecs[inIdx]);
            else           bus.in_valid = 1'b0;
            @(negedge clk);
            if (prevStall) checkOutput($sformatf("bp.holdValid%0d", c), 32'(bus.out_valid), 1);
            if (bus.out_valid) begin
                if (outIdx < 8) checkResult($sformatf("bp%0d.c%0d", outIdx, c), thrVecs[outIdx]);
                else            checkOutput("bp.extra", 1, 0);
                if (!bus.out_ready) checkOutput($sformatf("bp.inReady%0d", c), 32'(bus.in_ready), 0);
                else                outIdx++;
            end
            accept    = bus.in_valid && bus.in_ready;
            prevStall = bus.out_valid && !bus.out_ready;
            @(posedge clk);
            #1;
            if (accept) inIdx++;
        end
        checkOutput("bp.accepted", inIdx, 8);
        checkOutput("bp.count",    outIdx, 8);

        // Reset with a stalled result at the output and three more in flight.
        $display("[TB] reset in flight");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(thrVecs[i]);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rf.headValid", 32'(bus.out_valid), 1);
        checkResult("rf.head", thrVecs[0]);
        checkOutput("rf.inReadyStall", 32'(bus.in_ready), 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rf.outValid", 32'(bus.out_valid), 0);
        checkOutput("rf.diff",     32'(bus.diff),      0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("rf.inReady", 32'(bus.in_ready), 1);
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stray++;
        end
        checkOutput("rf.stray", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
